// File: rtl/ftoi_issue.sv
// ftoi_issue: issue/writeback sequencer around the float-to-int converter (FTOI ops with dest tag).
// Latency: accept at edge N, converter result captured at N+1, visible on out_* after N+1.
// Backpressure: credit-based in_ready = (count + s1_valid) < DEPTH from registered state only; FIFO absorbs writeback stalls.
// Optional feature: define FTOI_SAT_EN to saturate out-of-range inputs and flush |x| < 0.5 to zero.
module ftoi_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      cvt_x,
  input  logic [31:0]      cvt_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // launch stage: tracks the op whose result the converter produces next cycle
  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
`ifdef FTOI_SAT_EN
  logic             s1_sign;
  logic [7:0]       s1_exp;
`endif

  // output FIFO state
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [31:0]      mem_dat [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [CW:0]      occ;
  logic             accept;
  logic             push;
  logic             pop;
  logic [31:0]      push_dat;

  // the in-flight op already owns a FIFO slot, so it counts against the credit
  assign occ       = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign in_ready  = (occ < (CW+1)'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign cvt_x     = in_x;
  assign push      = s1_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // head entry is forced to zero when empty so the port reads 0 after reset
  assign out_data  = out_valid ? mem_dat[rd_ptr] : '0;
  assign out_tag   = out_valid ? mem_tag[rd_ptr] : '0;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    ptr_next = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // select the value written into the FIFO for the op leaving the launch stage
  always_comb begin
    push_dat = cvt_y;
`ifdef FTOI_SAT_EN
    if (s1_exp >= 8'd158) begin
      push_dat = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (s1_exp < 8'd126) begin
      push_dat = '0;
    end
`endif
  end

  // launch stage register, loaded on every accepted op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
`ifdef FTOI_SAT_EN
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
`endif
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_tag  <= in_tag;
`ifdef FTOI_SAT_EN
        s1_sign <= in_x[31];
        s1_exp  <= in_x[30:23];
`endif
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, written on the same edge the converter output is sampled
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat[wr_ptr] <= push_dat;
      mem_tag[wr_ptr] <= s1_tag;
    end
  end

  // the credit rule must make a push into a full FIFO unreachable
  assert property (@(posedge clk) disable iff (rst) !(push && (count == CW'(DEPTH))))
    else $error("ftoi_issue: push into full FIFO");

endmodule

// File: tb/tb_ftoi_issue.sv
// Testbench for ftoi_issue: bench-owned converter model, per-cycle scoreboard, directed vectors.
module tb_ftoi_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_x = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      cvt_x;
  logic [31:0]      cvt_y = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0;

  // expected results in acceptance order with the cycle they become visible
  logic [31:0]      q_dat [$];
  logic [TAG_W-1:0] q_tag [$];
  int               q_av  [$];
  // everything popped by the writeback side, for literal checks
  logic [31:0]      log_dat [$];
  logic [TAG_W-1:0] log_tag [$];

  ftoi_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
    .cvt_x(cvt_x), .cvt_y(cvt_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter: round half away from zero; out-of-range inputs give a recognisable junk value.
  function automatic logic [31:0] conv(input logic [31:0] x);
    logic [7:0]  e;
    logic [63:0] mant;
    logic [63:0] mag;
    int          s;
    e = x[30:23];
    if (e >= 8'd158) return 32'hDEAD_BEEF;
    if (e == 8'd0) return 32'h0;
    mant = {40'h0, 1'b1, x[22:0]};
    if (e >= 8'd150) begin
      mag = mant << (e - 8'd150);
    end else begin
      s = 150 - int'(e);
      if (s > 40) mag = 64'h0;
      else mag = (mant + (64'h1 << (s - 1))) >> s;
    end
    return x[31] ? (32'h0 - mag[31:0]) : mag[31:0];
  endfunction

  function automatic logic [31:0] expect_val(input logic [31:0] x);
`ifdef FTOI_SAT_EN
    if (x[30:23] >= 8'd158) return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (x[30:23] < 8'd126) return 32'h0;
`endif
    return conv(x);
  endfunction

  always @(posedge clk) cvt_y <= conv(cvt_x);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: inputs change just after posedge, so negedge sees the values of the coming edge.
  always @(negedge clk) begin
    logic exp_vld;
    if (rst) begin
      q_dat.delete(); q_tag.delete(); q_av.delete();
    end else begin
      exp_vld = (q_dat.size() > 0) && (q_av[0] <= cyc);
      chk("out_valid", {31'h0, out_valid}, {31'h0, exp_vld});
      chk("in_ready", {31'h0, in_ready}, {31'h0, (q_dat.size() < DEPTH)});
      if (exp_vld) begin
        chk("out_data", out_data, q_dat[0]);
        chk("out_tag", {26'h0, out_tag}, {26'h0, q_tag[0]});
        if (out_ready && out_valid) begin
          log_dat.push_back(out_data);
          log_tag.push_back(out_tag);
          void'(q_dat.pop_front()); void'(q_tag.pop_front()); void'(q_av.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q_dat.push_back(expect_val(in_x));
        q_tag.push_back(in_tag);
        q_av.push_back(cyc + 2);
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [TAG_W-1:0] tag);
    int n;
    in_x = x; in_tag = tag; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'h1, 32'h0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q_dat.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q_dat.size() > 0) chk("drain_timeout", q_dat.size(), 32'h0);
    #1;
  endtask

  logic [31:0] ints [6] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                            32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
  logic [31:0] sat_pos, sat_neg;
  bit          stream_done;
  int          base;

  initial begin
`ifdef FTOI_SAT_EN
    sat_pos = 32'h7FFF_FFFF; sat_neg = 32'h8000_0000;
`else
    sat_pos = 32'hDEAD_BEEF; sat_neg = 32'hDEAD_BEEF;
`endif
    // reset state
    #12;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_tag", {26'h0, out_tag}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // single op: 1.0 tag 5
    base = log_dat.size();
    send(32'h3F80_0000, 6'd5);
    #4; chk("single_s1_not_vis", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("single_vis", {31'h0, out_valid}, 32'h1);
    chk("single_in_ready", {31'h0, in_ready}, 32'h1);
    drain();
    chk("single_data", log_dat[base], 32'h1);
    chk("single_tag", {26'h0, log_tag[base]}, 32'd5);

    // rounding, back to back
    base = log_dat.size();
    send(32'h4020_0000, 6'd7);
    send(32'hC020_0000, 6'd8);
    drain();
    chk("round_pos", log_dat[base], 32'h3);
    chk("round_pos_tag", {26'h0, log_tag[base]}, 32'd7);
    chk("round_neg", log_dat[base+1], 32'hFFFF_FFFD);
    chk("round_neg_tag", {26'h0, log_tag[base+1]}, 32'd8);

    // backpressure: 6 ops against a stalled writeback
    base = log_dat.size();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(ints[k], TAG_W'(20 + k));
      end
      begin
        int a0;
        a0 = acc_cnt;
        repeat (12) @(posedge clk);
        #1;
        chk("bp_accepted", acc_cnt - a0, 32'd4);
        chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
        out_ready = 1'b1;
      end
    join
    drain();
    for (int k = 0; k < 6; k++) begin
      chk("bp_order", log_dat[base+k], k + 1);
      chk("bp_tag", {26'h0, log_tag[base+k]}, 20 + k);
    end

    // saturation and small-magnitude inputs
    base = log_dat.size();
    send(32'h4F00_0000, 6'd1);
    send(32'hFF80_0000, 6'd2);
    send(32'h3E80_0000, 6'd3);
    drain();
    chk("sat_pos", log_dat[base], sat_pos);
    chk("sat_neg", log_dat[base+1], sat_neg);
    chk("small_zero", log_dat[base+2], 32'h0);

    // streaming with random writeback stalls
    stream_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          logic [31:0] x;
          x = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 157)), 23'($urandom)};
          send(x, TAG_W'(k));
          if ($urandom_range(0, 9) == 0) begin @(posedge clk); #1; end
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // reset with 3 buffered and 1 in flight
    out_ready = 1'b0;
    send(32'h4000_0000, 6'd11);
    send(32'h4040_0000, 6'd12);
    send(32'h4080_0000, 6'd13);
    send(32'h40A0_0000, 6'd14);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    base = log_dat.size();
    send(32'h3F80_0000, 6'd9);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_count", log_dat.size() - base, 32'h1);
    chk("postrst_data", log_dat[base], 32'h1);
    chk("postrst_tag", {26'h0, log_tag[base]}, 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
